// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back for
// one instruction at a time, handshaking with instruction and data memories.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      instr,
    input  logic             zero_flag,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             rf_we,
    output logic             rf_wsel,
    output logic             wb_sel,
    output logic             alu_src_imm,
    output logic [2:0]       alu_op,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             busy,
    output logic             halted,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd5;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t           state_r;
    logic [5:0]       op_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             retire_s;
    logic             tmo_hit_s;
    logic             unused_s;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    endfunction

    // Only the opcode field is decoded here; the rest of the word feeds the datapath.
    assign unused_s = ^instr[25:0];

    // Retirement and data-memory timeout detection for the current cycle.
    always_comb begin
        retire_s  = 1'b0;
        tmo_hit_s = 1'b0;
        case (state_r)
            S_EXEC: begin
                if (op_r == OP_BEQ || op_r == OP_J || op_r == OP_HALT) begin
                    retire_s = 1'b1;
                end else begin
                    retire_s = 1'b0;
                end
            end
            S_MEM: begin
                // An ack arriving on the last allowed cycle still wins over the timeout.
                if (dmem_ack) begin
                    retire_s = (op_r == OP_SW);
                end else begin
                    tmo_hit_s = (tmo_cnt_r == TMO_LAST);
                end
            end
            S_WB: retire_s = 1'b1;
            default: begin
                retire_s  = 1'b0;
                tmo_hit_s = 1'b0;
            end
        endcase
    end

    // State sequencing, opcode latch, sticky error flags and retire counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            op_r       <= 6'd0;
            tmo_cnt_r  <= {TMO_W{1'b0}};
            illegal_op <= 1'b0;
            bus_err    <= 1'b0;
            instret    <= {CNT_W{1'b0}};
        end else begin
            if (retire_s) begin
                instret <= instret + CNT_ONE;
            end
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        op_r    <= instr[31:26];
                        state_r <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!op_legal(op_r)) begin
                        illegal_op <= 1'b1;
                        state_r    <= S_HALT;
                    end else begin
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_r)
                        OP_RTYPE, OP_ADDI: state_r <= S_WB;
                        OP_LW, OP_SW:      state_r <= S_MEM;
                        OP_BEQ, OP_J:      state_r <= S_FETCH;
                        OP_HALT:           state_r <= S_HALT;
                        default:           state_r <= S_HALT;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        tmo_cnt_r <= {TMO_W{1'b0}};
                        state_r   <= (op_r == OP_LW) ? S_WB : S_FETCH;
                    end else if (tmo_hit_s) begin
                        tmo_cnt_r <= {TMO_W{1'b0}};
                        bus_err   <= 1'b1;
                        state_r   <= S_HALT;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                    end
                end
                S_WB:    state_r <= S_FETCH;
                S_HALT:  state_r <= S_HALT;
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // Phase control decode from state and latched opcode.
    always_comb begin
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = PC_SEQ;
        rf_we       = 1'b0;
        rf_wsel     = 1'b0;
        wb_sel      = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = ALU_ADD;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        busy        = (state_r != S_IDLE) && (state_r != S_HALT);
        halted      = (state_r == S_HALT);
        case (state_r)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = PC_SEQ;
                end else begin
                    ir_we = 1'b0;
                    pc_we = 1'b0;
                end
            end
            S_EXEC: begin
                case (op_r)
                    OP_RTYPE: alu_op = ALU_FUNCT;
                    OP_ADDI, OP_LW, OP_SW: begin
                        alu_op      = ALU_ADD;
                        alu_src_imm = 1'b1;
                    end
                    OP_BEQ: begin
                        alu_op = ALU_SUB;
                        pc_src = PC_BRANCH;
                        pc_we  = zero_flag;
                    end
                    OP_J: begin
                        pc_we  = 1'b1;
                        pc_src = PC_JUMP;
                    end
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_MEM: begin
                dmem_req    = 1'b1;
                dmem_we     = (op_r == OP_SW);
                alu_op      = ALU_ADD;
                alu_src_imm = 1'b1;
            end
            S_WB: begin
                rf_we = 1'b1;
                case (op_r)
                    OP_RTYPE: begin
                        rf_wsel = 1'b0;
                        wb_sel  = 1'b0;
                    end
                    OP_ADDI: begin
                        rf_wsel = 1'b1;
                        wb_sel  = 1'b0;
                    end
                    OP_LW: begin
                        rf_wsel = 1'b1;
                        wb_sel  = 1'b1;
                    end
                    default: begin
                        rf_wsel = 1'b0;
                        wb_sel  = 1'b0;
                    end
                endcase
            end
            default: imem_req = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each phase's control vector and the
// retire counter are compared against hand-computed constants.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] instr;
    logic        zero_flag;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req, ir_we, pc_we, rf_we, rf_wsel, wb_sel, alu_src_imm;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op;
    logic        dmem_req, dmem_we, busy, halted, illegal_op, bus_err;
    logic [15:0] instret;
    logic [17:0] ctl;

    int vectors     = 0;
    int miscompares = 0;

    // Control vector bit weights
    localparam logic [17:0] IMR    = 18'h20000;
    localparam logic [17:0] IRW    = 18'h10000;
    localparam logic [17:0] PCW    = 18'h08000;
    localparam logic [17:0] SRC_J  = 18'h04000;
    localparam logic [17:0] SRC_BR = 18'h02000;
    localparam logic [17:0] RFW    = 18'h01000;
    localparam logic [17:0] WSEL   = 18'h00800;
    localparam logic [17:0] WBS    = 18'h00400;
    localparam logic [17:0] IMM    = 18'h00200;
    localparam logic [17:0] OP_FN  = 18'h00140;
    localparam logic [17:0] OP_SUB = 18'h00040;
    localparam logic [17:0] DRQ    = 18'h00020;
    localparam logic [17:0] DWE    = 18'h00010;
    localparam logic [17:0] BSY    = 18'h00008;
    localparam logic [17:0] HLT    = 18'h00004;
    localparam logic [17:0] ILL    = 18'h00002;
    localparam logic [17:0] BER    = 18'h00001;
    localparam logic [17:0] FETCH_ACK = IMR | IRW | PCW | BSY;

    multicycle_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .zero_flag(zero_flag),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .rf_wsel(rf_wsel), .wb_sel(wb_sel),
        .alu_src_imm(alu_src_imm), .alu_op(alu_op), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .busy(busy), .halted(halted), .illegal_op(illegal_op), .bus_err(bus_err),
        .instret(instret)
    );

    assign ctl = {imem_req, ir_we, pc_we, pc_src, rf_we, rf_wsel, wb_sel, alu_src_imm,
                  alu_op, dmem_req, dmem_we, busy, halted, illegal_op, bus_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the current cycle's controls mid-cycle, then move to the next cycle.
    task automatic cyc(input string tag, input logic [17:0] exp);
        #1;
        chk(tag, {14'd0, ctl}, {14'd0, exp});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("post_reset_ctl", {14'd0, ctl}, 32'd0);
        chk("post_reset_instret", {16'd0, instret}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; instr = 32'd0; zero_flag = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_ctl", {14'd0, ctl}, 32'd0);
        chk("reset_instret", {16'd0, instret}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Async reset in the middle of a pending fetch
        start = 1'b1;
        cyc("idle_start", 18'd0);
        start = 1'b0;
        #1;
        chk("fetch_wait", {14'd0, ctl}, {14'd0, IMR | BSY});
        rst = 1'b0;
        #1;
        chk("rst_async_ctl", {14'd0, ctl}, 32'd0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_idle_ctl", {14'd0, ctl}, 32'd0);
        chk("rst_idle_instret", {16'd0, instret}, 32'd0);

        // ADDI with both acks held high throughout
        start = 1'b1;
        cyc("addi_idle", 18'd0);
        start = 1'b0; instr = 32'h20010005; imem_ack = 1'b1; dmem_ack = 1'b1;
        cyc("addi_fetch", FETCH_ACK);
        cyc("addi_decode", BSY);
        cyc("addi_exec", IMM | BSY);
        cyc("addi_wb", RFW | WSEL | BSY);
        imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        chk("addi_instret", {16'd0, instret}, 32'd1);

        // LW with dmem_ack after three wait cycles
        instr = 32'h8C220004; imem_ack = 1'b1;
        cyc("lw_fetch", FETCH_ACK);
        imem_ack = 1'b0;
        cyc("lw_decode", BSY);
        cyc("lw_exec", IMM | BSY);
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", DRQ | IMM | BSY);
        dmem_ack = 1'b1;
        cyc("lw_mem_ack", DRQ | IMM | BSY);
        dmem_ack = 1'b0;
        cyc("lw_wb", RFW | WSEL | WBS | BSY);
        #1;
        chk("lw_back_fetch", {14'd0, ctl}, {14'd0, IMR | BSY});
        chk("lw_instret", {16'd0, instret}, 32'd2);

        // BEQ taken then not taken
        instr = 32'h10220003; imem_ack = 1'b1; zero_flag = 1'b1;
        cyc("beq1_fetch", FETCH_ACK);
        imem_ack = 1'b0;
        cyc("beq1_decode", BSY);
        cyc("beq1_exec", PCW | SRC_BR | OP_SUB | BSY);
        #1;
        chk("beq1_instret", {16'd0, instret}, 32'd3);
        imem_ack = 1'b1; zero_flag = 1'b0;
        cyc("beq2_fetch", FETCH_ACK);
        imem_ack = 1'b0;
        cyc("beq2_decode", BSY);
        cyc("beq2_exec", SRC_BR | OP_SUB | BSY);
        #1;
        chk("beq2_instret", {16'd0, instret}, 32'd4);

        // J
        instr = 32'h08000010; imem_ack = 1'b1;
        cyc("j_fetch", FETCH_ACK);
        imem_ack = 1'b0;
        cyc("j_decode", BSY);
        cyc("j_exec", PCW | SRC_J | BSY);
        #1;
        chk("j_instret", {16'd0, instret}, 32'd5);

        // R-type
        instr = 32'h00221820; imem_ack = 1'b1;
        cyc("r_fetch", FETCH_ACK);
        imem_ack = 1'b0;
        cyc("r_decode", BSY);
        cyc("r_exec", OP_FN | BSY);
        cyc("r_wb", RFW | BSY);
        #1;
        chk("r_instret", {16'd0, instret}, 32'd6);

        // SW with immediate ack
        instr = 32'hAC220008; imem_ack = 1'b1;
        cyc("sw_fetch", FETCH_ACK);
        imem_ack = 1'b0;
        cyc("sw_decode", BSY);
        cyc("sw_exec", IMM | BSY);
        dmem_ack = 1'b1;
        cyc("sw_mem_ack", DRQ | DWE | IMM | BSY);
        dmem_ack = 1'b0;
        #1;
        chk("sw_back_fetch", {14'd0, ctl}, {14'd0, IMR | BSY});
        chk("sw_instret", {16'd0, instret}, 32'd7);

        // SW never acknowledged: bus error after 16 request cycles
        imem_ack = 1'b1;
        cyc("swt_fetch", FETCH_ACK);
        imem_ack = 1'b0;
        cyc("swt_decode", BSY);
        cyc("swt_exec", IMM | BSY);
        for (int i = 0; i < 16; i++) cyc("swt_mem_wait", DRQ | DWE | IMM | BSY);
        start = 1'b1;
        cyc("swt_halt", HLT | BER);
        start = 1'b0;
        cyc("swt_halt_start_ignored", HLT | BER);
        #1;
        chk("swt_instret", {16'd0, instret}, 32'd7);

        // SW acknowledged on the 16th request cycle still succeeds
        do_reset();
        start = 1'b1;
        cyc("swl_idle", 18'd0);
        start = 1'b0; imem_ack = 1'b1;
        cyc("swl_fetch", FETCH_ACK);
        imem_ack = 1'b0;
        cyc("swl_decode", BSY);
        cyc("swl_exec", IMM | BSY);
        for (int i = 0; i < 15; i++) cyc("swl_mem_wait", DRQ | DWE | IMM | BSY);
        dmem_ack = 1'b1;
        cyc("swl_mem_ack16", DRQ | DWE | IMM | BSY);
        dmem_ack = 1'b0;
        #1;
        chk("swl_back_fetch", {14'd0, ctl}, {14'd0, IMR | BSY});
        chk("swl_instret", {16'd0, instret}, 32'd1);

        // Illegal opcode 0x3E
        instr = 32'hF8000000; imem_ack = 1'b1;
        cyc("ill_fetch", FETCH_ACK);
        imem_ack = 1'b0;
        cyc("ill_decode", BSY);
        cyc("ill_halt", HLT | ILL);
        #1;
        chk("ill_instret", {16'd0, instret}, 32'd1);

        // HALT opcode 0x3F
        do_reset();
        start = 1'b1;
        cyc("hlt_idle", 18'd0);
        start = 1'b0; instr = 32'hFC000000; imem_ack = 1'b1;
        cyc("hlt_fetch", FETCH_ACK);
        imem_ack = 1'b0;
        cyc("hlt_decode", BSY);
        cyc("hlt_exec", BSY);
        cyc("hlt_halt", HLT);
        #1;
        chk("hlt_instret", {16'd0, instret}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences the TOP datapath (PC, instruction memory, register file Rw/R1/R2, ALU, data memory) one instruction at a time over several cycles.
- Raises the enables and selects for each phase.
- Waits on req/ack handshakes to both memories.
- Stops on a halt instruction, an illegal opcode or a data-memory timeout.

Parameters:
TIMEOUT, 16, max cycles dmem_req may stay unacknowledged before bus error
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; leaves IDLE
instr  in  32  instruction word from imem, valid while imem_ack=1
zero_flag  in  1  ALU zero flag (ALU_Flag bit 0)
imem_ack  in  1  instruction memory data valid
dmem_ack  in  1  data memory access complete
imem_req  out  1  fetch request
ir_we  out  1  load instruction register
pc_we  out  1  PC write enable
pc_src  out  2  0=PC+4, 1=branch target, 2=jump target
rf_we  out  1  register file write (Rw)
rf_wsel  out  1  0=rd dest, 1=rt dest
wb_sel  out  1  0=ALU result, 1=memory data
alu_src_imm  out  1  ALU operand B: 0=R2, 1=sign-extended imm
alu_op  out  3  0=ADD,1=SUB,2=AND,3=OR,4=SLT,5=use funct
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (valid with dmem_req)
busy  out  1  state not IDLE/HALT
halted  out  1  in HALT
illegal_op  out  1  sticky; set by undefined opcode
bus_err  out  1  sticky; set by dmem timeout
instret  out  CNT_W  retired instruction count, wraps

Behaviour:
- Reset (async, rst=0):
  - State to IDLE.
  - All outputs 0, instret 0, opcode latch 0, timeout counter 0.
  - Applies mid-transaction too; an outstanding req is dropped immediately.
- Decoded outputs:
  - All control outputs are combinational from state and the latched opcode. No glitch requirement.
  - Any output not listed for a state is 0.
- Opcodes, instr[31:26]:
  - 000000 R-type
  - 001000 ADDI
  - 100011 LW
  - 101011 SW
  - 000100 BEQ
  - 000010 J
  - 111111 HALT
  - All others illegal.
- IDLE: wait for start=1, then go to FETCH next cycle.
- FETCH:
  - imem_req=1 every cycle until imem_ack.
  - In the ack cycle: ir_we=1, pc_we=1, pc_src=0. Latch opcode. Go to DECODE.
- DECODE:
  - One cycle, no outputs.
  - Illegal opcode: set illegal_op, go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - R-type: alu_op=5, go to WB.
  - ADDI/LW/SW: alu_op=0, alu_src_imm=1. ADDI goes to WB; LW/SW go to MEM.
  - BEQ: alu_op=1, pc_src=1, pc_we=zero_flag. Retire, go to FETCH.
  - J: pc_we=1, pc_src=2. Retire, go to FETCH.
  - HALT: retire, go to HALT.
- MEM:
  - dmem_req=1; dmem_we=1 for SW. alu_op=0, alu_src_imm=1 held.
  - Timeout counter increments each cycle without ack.
  - dmem_ack: counter cleared. LW goes to WB; SW retires and goes to FETCH.
  - Counter reaches TIMEOUT with no ack: set bus_err, drop req, go to HALT. The instruction is not retired.
  - Ack in the same cycle the counter hits TIMEOUT counts as success.
- WB:
  - rf_we=1.
  - R-type: rf_wsel=0, wb_sel=0. ADDI: rf_wsel=1, wb_sel=0. LW: rf_wsel=1, wb_sel=1.
  - Retire, go to FETCH.
- HALT:
  - halted=1. Absorbing; only rst exits.
  - start is ignored here and in all non-IDLE states.
- Retire: instret += 1 on the retiring cycle; wraps from all-ones to 0.
- Latency in cycles with zero-wait memories (ack in the first req cycle):
  - R-type/ADDI: 4
  - LW: 5
  - SW: 4
  - BEQ/J: 3
- Acks:
  - imem_ack outside FETCH is ignored.
  - dmem_ack outside MEM is ignored.

Test Plan:
- Reset mid-FETCH with imem_req=1, rst pulsed low between clock edges → all outputs 0 immediately, before the next edge; after release, state IDLE, instret=0.
- start, instr=ADDI (0x20010005), imem_ack and dmem_ack immediate → imem_req/ir_we/pc_we in cycle 1; cycle 3 alu_src_imm=1, alu_op=0; cycle 4 rf_we=1, rf_wsel=1, wb_sel=0; instret=1.
- LW with dmem_ack delayed 3 cycles → dmem_req held 4 cycles, dmem_we=0; then WB with wb_sel=1, rf_wsel=1; total 8 cycles.
- BEQ twice, zero_flag=1 then zero_flag=0 → EXEC pc_we=1, pc_src=1 then pc_we=0; each 3 cycles; instret=2.
- SW with dmem_ack never asserted, TIMEOUT=16 → dmem_req=1, dmem_we=1 for 16 cycles; then bus_err=1, halted=1, instret unchanged; later start pulse ignored.
- instr opcode 0x3E → illegal_op=1, halted=1 after DECODE; no rf_we, no dmem_req. HALT opcode 0x3F instead → halted=1, illegal_op=0, instret+1.
